// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with prescaler, load, wrap/saturate, terminal-count pulse and sticky flags.
// Latency: count/tc/flags update one edge after the request; at_max/at_min decode count combinationally.
// Backpressure: none; every enabled edge advances the prescaler, and load always takes effect.
module updown_mod_counter #(
    parameter int     N_BITS    = 8,
    parameter longint MOD_VALUE = longint'(1) << N_BITS,
    parameter bit     SATURATE  = 1'b0,
    parameter int     PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up,
    input  logic              load,
    input  logic [N_BITS-1:0] load_value,
    input  logic              clear_flags,
    output logic [N_BITS-1:0] count,
    output logic              tc,
    output logic              overflow,
    output logic              underflow,
    output logic              at_max,
    output logic              at_min
);

    localparam int                PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N_BITS-1:0] MAX_VAL  = N_BITS'(MOD_VALUE - 1);
    localparam logic [PW-1:0]     PRE_LAST = PW'(PRESCALE - 1);

    generate
        if (N_BITS < 1 || N_BITS > 32)
            $error("updown_mod_counter: N_BITS out of range");
        if (MOD_VALUE < 2 || MOD_VALUE > (longint'(1) << N_BITS))
            $error("updown_mod_counter: MOD_VALUE out of range");
        if (PRESCALE < 1)
            $error("updown_mod_counter: PRESCALE must be >= 1");
    endgenerate

    logic [PW-1:0] presc;
    logic          step;
    logic          ovf_evt;
    logic          udf_evt;

    assign at_max = (count == MAX_VAL);
    assign at_min = (count == '0);

    // A step only exists when load is idle; load outranks the prescaler.
    assign step    = en & ~load & (presc == PRE_LAST);
    assign ovf_evt = step &  up & at_max;
    assign udf_evt = step & ~up & at_min;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
            presc <= '0;
            tc    <= 1'b0;
        end else if (load) begin
            count <= (load_value > MAX_VAL) ? MAX_VAL : load_value;
            presc <= '0;
            tc    <= 1'b0;
        end else if (en) begin
            if (presc == PRE_LAST) begin
                presc <= '0;
                if (up) begin
                    if (at_max) begin
                        count <= SATURATE ? count : '0;
                        tc    <= 1'b1;
                    end else begin
                        count <= count + N_BITS'(1);
                        tc    <= 1'b0;
                    end
                end else begin
                    if (at_min) begin
                        count <= SATURATE ? count : MAX_VAL;
                        tc    <= 1'b1;
                    end else begin
                        count <= count - N_BITS'(1);
                        tc    <= 1'b0;
                    end
                end
            end else begin
                presc <= presc + PW'(1);
                tc    <= 1'b0;
            end
        end else begin
            tc <= 1'b0;
        end
    end

    // Set beats clear when a boundary event lands on the same edge as clear_flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (overflow  & ~clear_flags) | ovf_evt;
            underflow <= (underflow & ~clear_flags) | udf_evt;
        end
    end

endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboarded bench: three counter configurations share stimulus; each test checks one of them.
module tb_updown_mod_counter;

    typedef struct packed {
        logic [3:0] count;
        logic       tc;
        logic       ovf;
        logic       udf;
        logic       mx;
        logic       mn;
    } obs_t;

    typedef struct packed {
        logic       en;
        logic       up;
        logic       ld;
        logic       cf;
        logic [3:0] lv;
    } stim_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0, up = 1'b0, load = 1'b0, clear_flags = 1'b0;
    logic [3:0] lv = '0;

    logic [2:0] w_count, s_count;
    logic [3:0] p_count;
    logic w_tc, w_ovf, w_udf, w_max, w_min;
    logic s_tc, s_ovf, s_udf, s_max, s_min;
    logic p_tc, p_ovf, p_udf, p_max, p_min;

    obs_t q[$];
    int   n_pass = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    updown_mod_counter #(.N_BITS(3), .MOD_VALUE(6), .SATURATE(1'b0), .PRESCALE(1)) u_wrap (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv[2:0]),
        .clear_flags(clear_flags), .count(w_count), .tc(w_tc), .overflow(w_ovf),
        .underflow(w_udf), .at_max(w_max), .at_min(w_min));

    updown_mod_counter #(.N_BITS(3), .MOD_VALUE(6), .SATURATE(1'b1), .PRESCALE(1)) u_sat (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv[2:0]),
        .clear_flags(clear_flags), .count(s_count), .tc(s_tc), .overflow(s_ovf),
        .underflow(s_udf), .at_max(s_max), .at_min(s_min));

    updown_mod_counter #(.N_BITS(4), .MOD_VALUE(16), .SATURATE(1'b0), .PRESCALE(3)) u_pre (
        .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_value(lv),
        .clear_flags(clear_flags), .count(p_count), .tc(p_tc), .overflow(p_ovf),
        .underflow(p_udf), .at_max(p_max), .at_min(p_min));

    function automatic obs_t mk(int c, bit t, bit o, bit u, bit mx, bit mn);
        obs_t r;
        r.count = 4'(c);
        r.tc = t; r.ovf = o; r.udf = u; r.mx = mx; r.mn = mn;
        return r;
    endfunction

    function automatic stim_t st(bit e, bit u, bit l, bit c, int v);
        stim_t r;
        r.en = e; r.up = u; r.ld = l; r.cf = c; r.lv = 4'(v);
        return r;
    endfunction

    function automatic obs_t obs_wrap();
        return {1'b0, w_count, w_tc, w_ovf, w_udf, w_max, w_min};
    endfunction

    function automatic obs_t obs_sat();
        return {1'b0, s_count, s_tc, s_ovf, s_udf, s_max, s_min};
    endfunction

    function automatic obs_t obs_pre();
        return {p_count, p_tc, p_ovf, p_udf, p_max, p_min};
    endfunction

    task automatic apply(input stim_t s);
        en = s.en; up = s.up; load = s.ld; clear_flags = s.cf; lv = s.lv;
    endtask

    task automatic do_reset();
        @(negedge clk);
        apply(st(0, 0, 0, 0, 0));
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t e, o;
        do_reset();
        apply(st(0, 0, 1, 0, 4));
        q.push_back(mk(4, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        e = q.pop_front(); o = obs_wrap(); n_total++;
        if (o !== e) $display("FAIL reset_load4 got %p need %p", o, e); else n_pass++;
        @(negedge clk);
        apply(st(1, 1, 0, 0, 0));
        @(posedge clk); #2;
        reset = 1'b1;
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        #1;
        e = q.pop_front(); o = obs_wrap(); n_total++;
        if (o !== e) $display("FAIL reset_async got %p need %p", o, e); else n_pass++;
        q.push_back(mk(0, 0, 0, 0, 0, 1));
        @(posedge clk); #1;
        e = q.pop_front(); o = obs_wrap(); n_total++;
        if (o !== e) $display("FAIL reset_held got %p need %p", o, e); else n_pass++;
        // Reset mid-prescale: u_pre must need three fresh enabled edges afterwards.
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            q.push_back(mk(i == 2 ? 1 : 0, 0, 0, 0, 0, i != 2));
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_pre(); n_total++;
            if (o !== e) $display("FAIL reset_presc[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_wrap_up();
        stim_t s[8];
        obs_t  x[8];
        obs_t  e, o;
        s = '{st(0,0,1,1,0), st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0),
              st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0), st(0,1,0,0,0)};
        x = '{mk(0,0,0,0,0,1), mk(1,0,0,0,0,0), mk(2,0,0,0,0,0), mk(3,0,0,0,0,0),
              mk(4,0,0,0,0,0), mk(5,0,0,0,1,0), mk(0,1,1,0,0,1), mk(0,0,1,0,0,1)};
        do_reset();
        for (int i = 0; i < 8; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_wrap(); n_total++;
            if (o !== e) $display("FAIL wrap_up[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_sat_down();
        stim_t s[5];
        obs_t  x[5];
        obs_t  e, o;
        s = '{st(0,0,1,0,0), st(1,0,0,0,0), st(1,0,0,0,0), st(1,0,0,0,0), st(0,0,0,0,0)};
        x = '{mk(0,0,0,0,0,1), mk(0,1,0,1,0,1), mk(0,1,0,1,0,1), mk(0,1,0,1,0,1),
              mk(0,0,0,1,0,1)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_sat(); n_total++;
            if (o !== e) $display("FAIL sat_down[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_sat_up();
        stim_t s[5];
        obs_t  x[5];
        obs_t  e, o;
        s = '{st(1,0,1,0,6), st(1,1,0,0,0), st(1,1,0,0,0), st(1,0,0,0,0), st(0,0,0,1,0)};
        x = '{mk(5,0,0,0,1,0), mk(5,1,1,0,1,0), mk(5,1,1,0,1,0), mk(4,0,1,0,0,0),
              mk(4,0,0,0,0,0)};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_sat(); n_total++;
            if (o !== e) $display("FAIL sat_up[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_clamp();
        stim_t s[4];
        obs_t  x[4];
        obs_t  e, o;
        s = '{st(1,1,1,0,7), st(1,1,0,0,0), st(1,1,1,0,3), st(1,1,1,0,5)};
        x = '{mk(5,0,0,0,1,0), mk(0,1,1,0,0,1), mk(3,0,1,0,0,0), mk(5,0,1,0,1,0)};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_wrap(); n_total++;
            if (o !== e) $display("FAIL load_clamp[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_prescale();
        stim_t s[11];
        obs_t  x[11];
        obs_t  e, o;
        s = '{st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0),
              st(0,1,0,0,0), st(0,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0),
              st(1,1,0,0,0), st(1,0,0,0,0), st(1,0,0,0,0)};
        x = '{mk(0,0,0,0,0,1), mk(0,0,0,0,0,1), mk(1,0,0,0,0,0), mk(1,0,0,0,0,0),
              mk(1,0,0,0,0,0), mk(1,0,0,0,0,0), mk(1,0,0,0,0,0), mk(2,0,0,0,0,0),
              mk(2,0,0,0,0,0), mk(2,0,0,0,0,0), mk(1,0,0,0,0,0)};
        do_reset();
        for (int i = 0; i < 11; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_pre(); n_total++;
            if (o !== e) $display("FAIL prescale_edge%0d got %p need %p", i + 1, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_load_presc();
        stim_t s[10];
        obs_t  x[10];
        obs_t  e, o;
        s = '{st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,1,0,9), st(1,1,0,0,0), st(1,1,0,0,0),
              st(1,1,0,0,0), st(1,1,1,0,15), st(1,1,0,0,0), st(1,1,0,0,0), st(1,1,0,0,0)};
        x = '{mk(0,0,0,0,0,1), mk(0,0,0,0,0,1), mk(9,0,0,0,0,0), mk(9,0,0,0,0,0),
              mk(9,0,0,0,0,0), mk(10,0,0,0,0,0), mk(15,0,0,0,1,0), mk(15,0,0,0,1,0),
              mk(15,0,0,0,1,0), mk(0,1,1,0,0,1)};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_pre(); n_total++;
            if (o !== e) $display("FAIL load_presc[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    task automatic test_flag_collision();
        stim_t s[4];
        obs_t  x[4];
        obs_t  e, o;
        s = '{st(1,0,0,0,0), st(1,1,0,1,0), st(0,0,0,0,0), st(1,0,0,1,0)};
        x = '{mk(5,1,0,1,1,0), mk(0,1,1,0,0,1), mk(0,0,1,0,0,1), mk(5,1,0,1,1,0)};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            apply(s[i]); q.push_back(x[i]);
            @(posedge clk); #1;
            e = q.pop_front(); o = obs_wrap(); n_total++;
            if (o !== e) $display("FAIL flag_collision[%0d] got %p need %p", i, o, e); else n_pass++;
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_wrap_up();
        test_sat_down();
        test_sat_up();
        test_load_clamp();
        test_prescale();
        test_load_presc();
        test_flag_collision();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
